// File: rtl/rv_pkg.sv
// Shared register-file constants: default geometry and the hard-wired zero register index.
package rv_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/register_file_wb_if.sv
// Writeback / decode-read / scoreboard bus between the pipeline and the register file.
interface register_file_wb_if #(
  parameter int DATA_W = rv_pkg::RF_DATA_W,
  parameter int ADDR_W = rv_pkg::RF_ADDR_W
);
  logic              RegWriteW;
  logic [ADDR_W-1:0] rdW;
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] rs1D;
  logic [ADDR_W-1:0] rs2D;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              SetBusy;
  logic [ADDR_W-1:0] rdBusy;
  logic              BusyRs1;
  logic              BusyRs2;
  logic              BusyAny;

  modport master (
    output RegWriteW, rdW, ResultW, rs1D, rs2D, SetBusy, rdBusy,
    input  RD1, RD2, BusyRs1, BusyRs2, BusyAny
  );

  modport slave (
    input  RegWriteW, rdW, ResultW, rs1D, rs2D, SetBusy, rdBusy,
    output RD1, RD2, BusyRs1, BusyRs2, BusyAny
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register for operands owned by the multi-cycle unit.
module reg_scoreboard #(
  parameter int ADDR_W = rv_pkg::RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_idx,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_idx,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  output logic              o_busy_rs1,
  output logic              o_busy_rs2,
  output logic              o_busy_any
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Set is applied after clear so a freshly issued producer wins a same-index collision.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set) w_busy_nxt[i_set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so all flops sample pre-edge values together.
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Bit 0 is never set, so index 0 naturally reports not-busy.
  assign o_busy_rs1 = r_busy[i_rs1] && !(i_clr && (i_clr_idx == i_rs1));
  assign o_busy_rs2 = r_busy[i_rs2] && !(i_clr && (i_clr_idx == i_rs2));
  assign o_busy_any = |r_busy;
endmodule

// File: rtl/register_file_wb.sv
// Architectural register file: W-stage write, two bypassed decode reads, pending-write scoreboard.
module register_file_wb
  import rv_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  register_file_wb_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;

  // x0 has no storage; reads of index 0 are muxed to zero before the array.
  logic [DATA_W-1:0] r_regs [1:NREGS-1];
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wr_en = bus.RegWriteW && (bus.rdW != REG_ZERO);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      // NOTE: the array is reset because reads must return 0 for every index out of reset.
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.rdW] <= bus.ResultW;
    end
  end

  always_comb begin
    w_rd1 = '0;
    if (bus.rs1D == REG_ZERO)                           w_rd1 = '0;
    else if (bus.RegWriteW && (bus.rdW == bus.rs1D))    w_rd1 = bus.ResultW;
    else                                                w_rd1 = r_regs[bus.rs1D];
  end

  always_comb begin
    w_rd2 = '0;
    if (bus.rs2D == REG_ZERO)                           w_rd2 = '0;
    else if (bus.RegWriteW && (bus.rdW == bus.rs2D))    w_rd2 = bus.ResultW;
    else                                                w_rd2 = r_regs[bus.rs2D];
  end

  assign bus.RD1 = w_rd1;
  assign bus.RD2 = w_rd2;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (CLK),
    .rst_n      (RESETn),
    .i_set      (bus.SetBusy),
    .i_set_idx  (bus.rdBusy),
    .i_clr      (bus.RegWriteW),
    .i_clr_idx  (bus.rdW),
    .i_rs1      (bus.rs1D),
    .i_rs2      (bus.rs2D),
    .o_busy_rs1 (bus.BusyRs1),
    .o_busy_rs2 (bus.BusyRs2),
    .o_busy_any (bus.BusyAny)
  );
endmodule

// File: tb/tb_register_file_wb.sv
// Directed and reference-model checks of the writeback register file and its scoreboard.
module tb_register_file_wb;
  logic CLK = 1'b0;
  logic RESETn;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  register_file_wb_if bus ();

  register_file_wb dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.RegWriteW = 1'b0; bus.rdW = '0; bus.ResultW = '0;
    bus.rs1D = '0; bus.rs2D = '0; bus.SetBusy = 1'b0; bus.rdBusy = '0;
  endtask

  // Advance one clock; inputs change just after the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.rs1D = 5'(i); bus.rs2D = 5'(31 - i);
      #1;
      check({tag, "_rd1"}, bus.RD1, 32'h0);
      check({tag, "_rd2"}, bus.RD2, 32'h0);
    end
    check({tag, "_busyany"}, {31'h0, bus.BusyAny}, 32'h0);
  endtask

  initial begin
    logic        we, sb;
    logic [4:0]  rdw, rdb, r1, r2;
    logic [31:0] res, e1, e2;
    logic        eb1, eb2;

    idle();
    RESETn = 1'b0;
    @(negedge CLK);
    check_all_zero("reset_init");
    RESETn = 1'b1;
    tick();

    // Plain write then read; write to x0 is dropped.
    bus.RegWriteW = 1'b1; bus.rdW = 5'd5; bus.ResultW = 32'hDEADBEEF;
    tick();
    idle(); bus.rs1D = 5'd5; #1;
    check("write_x5", bus.RD1, 32'hDEADBEEF);
    tick();
    bus.RegWriteW = 1'b1; bus.rdW = 5'd0; bus.ResultW = 32'h1234; bus.rs1D = 5'd0; #1;
    check("x0_no_bypass", bus.RD1, 32'h0);
    tick();
    idle(); #1;
    check("x0_after_write", bus.RD1, 32'h0);

    // Same-cycle write-through on both ports.
    bus.RegWriteW = 1'b1; bus.rdW = 5'd7; bus.ResultW = 32'hA5A5A5A5;
    bus.rs1D = 5'd7; bus.rs2D = 5'd7; #1;
    check("bypass_rd1", bus.RD1, 32'hA5A5A5A5);
    check("bypass_rd2", bus.RD2, 32'hA5A5A5A5);
    tick();
    idle(); bus.rs1D = 5'd7; #1;
    check("x7_stored", bus.RD1, 32'hA5A5A5A5);

    // Scoreboard set, same-cycle satisfaction, clear.
    bus.SetBusy = 1'b1; bus.rdBusy = 5'd9;
    tick();
    idle(); bus.rs2D = 5'd9; #1;
    check("busy_rs2_set", {31'h0, bus.BusyRs2}, 32'h1);
    check("busy_any_set", {31'h0, bus.BusyAny}, 32'h1);
    check("busy_rs1_x0", {31'h0, bus.BusyRs1}, 32'h0);
    bus.RegWriteW = 1'b1; bus.rdW = 5'd9; bus.ResultW = 32'h99; #1;
    check("busy_rs2_wb", {31'h0, bus.BusyRs2}, 32'h0);
    check("busy_any_wb", {31'h0, bus.BusyAny}, 32'h1);
    tick();
    idle(); bus.rs2D = 5'd9; #1;
    check("busy_rs2_clr", {31'h0, bus.BusyRs2}, 32'h0);
    check("busy_any_clr", {31'h0, bus.BusyAny}, 32'h0);

    // Set/clear collision: set wins.
    bus.SetBusy = 1'b1; bus.rdBusy = 5'd3;
    tick();
    bus.RegWriteW = 1'b1; bus.rdW = 5'd3; bus.ResultW = 32'h33;
    tick();
    idle(); bus.rs1D = 5'd3; #1;
    check("collide_rs1", {31'h0, bus.BusyRs1}, 32'h1);
    check("collide_any", {31'h0, bus.BusyAny}, 32'h1);
    check("collide_data", bus.RD1, 32'h33);
    bus.RegWriteW = 1'b1; bus.rdW = 5'd3; bus.ResultW = 32'h34;
    tick();
    idle(); bus.SetBusy = 1'b1; bus.rdBusy = 5'd0;
    tick();
    idle(); #1;
    check("set_x0_any", {31'h0, bus.BusyAny}, 32'h0);

    // Asynchronous reset mid-run with busy bits pending.
    bus.SetBusy = 1'b1; bus.rdBusy = 5'd12;
    tick();
    idle(); #1;
    check("pre_reset_any", {31'h0, bus.BusyAny}, 32'h1);
    RESETn = 1'b0; #1;
    check_all_zero("reset_mid");
    @(negedge CLK);
    RESETn = 1'b1;
    tick();
    bus.rs1D = 5'd5; bus.rs2D = 5'd12; #1;
    check("post_reset_x5", bus.RD1, 32'h0);
    check("post_reset_busy12", {31'h0, bus.BusyRs2}, 32'h0);

    // Randomised traffic against a reference model.
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    for (int c = 0; c < 10000; c++) begin
      we  = ($urandom_range(0, 1) == 1);
      sb  = ($urandom_range(0, 3) == 0);
      rdw = 5'($urandom_range(0, 31));
      rdb = 5'($urandom_range(0, 31));
      r1  = 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      res = $urandom;
      bus.RegWriteW = we; bus.rdW = rdw; bus.ResultW = res;
      bus.SetBusy = sb; bus.rdBusy = rdb; bus.rs1D = r1; bus.rs2D = r2;
      e1  = (r1 == 0) ? 32'h0 : (we && rdw == r1) ? res : m_regs[r1];
      e2  = (r2 == 0) ? 32'h0 : (we && rdw == r2) ? res : m_regs[r2];
      eb1 = (r1 != 0) && m_busy[r1] && !(we && rdw == r1);
      eb2 = (r2 != 0) && m_busy[r2] && !(we && rdw == r2);
      #1;
      check("rnd_rd1", bus.RD1, e1);
      check("rnd_rd2", bus.RD2, e2);
      check("rnd_busy1", {31'h0, bus.BusyRs1}, {31'h0, eb1});
      check("rnd_busy2", {31'h0, bus.BusyRs2}, {31'h0, eb2});
      check("rnd_busyany", {31'h0, bus.BusyAny}, {31'h0, |m_busy});
      if (we && rdw != 0) m_regs[rdw] = res;
      if (we) m_busy[rdw] = 1'b0;
      if (sb && rdb != 0) m_busy[rdb] = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
